// File: rtl/display_pkg.sv
// Shared display definitions: framebuffer geometry, VGA 640x480@60 timing,
// plot write request and the shift-add framebuffer address helper.
package display_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_ADDR_W = 17;
  localparam int FB_DEPTH  = FB_W * FB_H;
  localparam int XMAX      = FB_W - 1;
  localparam int YMAX      = FB_H - 1;
  localparam int AXIS_ROW  = 120;

  // scan counters are 10 bits; every supported timing must total <= 1024
  localparam int CNT_W = 10;

  localparam int VGA_PIX_DIV  = 2;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic                 en;
    logic [FB_ADDR_W-1:0] addr;
    logic                 data;
  } fb_wr_t;

  // row*320 + col as row*256 + row*64 + col, no multiplier
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [8:0] col,
                                                    input logic [8:0] row);
    return FB_ADDR_W'({row, 8'b0}) + FB_ADDR_W'({row, 6'b0}) + FB_ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA scan timing: pixel-enable divider, hc/vc scan counters and the
// active / sync region decode (syncs active low).
module vga_timing
  import display_pkg::*;
#(
  parameter int PIX_DIV  = VGA_PIX_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clock,
  input  logic             resetn,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             pe,
  output logic             active,
  output logic             hs_n,
  output logic             vs_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div;

  assign pe = (div == DIV_W'(PIX_DIV - 1));

  // divider counts 0..PIX_DIV-1; pe is its terminal count
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  div <= '0;
    else if (pe)  div <= '0;
    else          div <= div + 1'b1;
  end

  // raster counters, advancing one pixel per pe
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hc <= '0;
      vc <= '0;
    end else if (pe) begin
      if (hc == CNT_W'(H_TOTAL - 1)) begin
        hc <= '0;
        vc <= (vc == CNT_W'(V_TOTAL - 1)) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  assign active = (hc < CNT_W'(H_ACTIVE)) && (vc < CNT_W'(V_ACTIVE));
  assign hs_n   = !((hc >= CNT_W'(H_ACTIVE + H_FP)) &&
                    (hc <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n   = !((vc >= CNT_W'(V_ACTIVE + V_FP)) &&
                    (vc <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/plot_scanout.sv
// Plotter-to-VGA scanout: 1-bit 320x240 framebuffer written from the plot
// port, scanned out as 640x480 with each stored pixel doubled in x and y.
// Outputs are registered on pe and lag the scan counters by one pixel.
// Build option: PLOT_SCANOUT_AXIS_EN overlays a solid line on framebuffer
// row AXIS_ROW (two VGA lines tall).
module plot_scanout
  import display_pkg::*;
#(
  parameter int PIX_DIV  = VGA_PIX_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic       color,
  input  logic       plot,
  output logic       vga_pix,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       frame_start
);

  logic [CNT_W-1:0]     hc, vc;
  logic                 pe, active, hs_n, vs_n;
  logic                 mem [0:FB_DEPTH-1];
  logic                 rd_data, pix_next;
  logic [FB_ADDR_W-1:0] rd_addr;
  fb_wr_t               wr;

  vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock (clock),
    .resetn(resetn),
    .hc    (hc),
    .vc    (vc),
    .pe    (pe),
    .active(active),
    .hs_n  (hs_n),
    .vs_n  (vs_n)
  );

  // out-of-range coordinates never reach the RAM
  always_comb begin
    wr      = '0;
    wr.en   = plot && (x <= 9'(XMAX)) && (y <= 8'(YMAX));
    wr.addr = fb_addr(x, {1'b0, y});
    wr.data = color;
  end

  // each framebuffer cell covers a 2x2 block of VGA pixels
  assign rd_addr = fb_addr(hc[CNT_W-1:1], vc[CNT_W-1:1]);

  // framebuffer write port; no reset, contents survive resetn
  always_ff @(posedge clock) begin
    if (wr.en) mem[wr.addr] <= wr.data;
  end

  // synchronous read; a same-cycle write to this address is not seen
  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
  end

`ifdef PLOT_SCANOUT_AXIS_EN
  assign pix_next = active & (rd_data | (vc[CNT_W-1:1] == 9'(AXIS_ROW)));
`else
  assign pix_next = active & rd_data;
`endif

  // output stage: all pins updated together on pe, one pixel behind hc/vc
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_pix     <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pe && (hc == '0) && (vc == '0);
      if (pe) begin
        vga_pix     <= pix_next;
        vga_hs      <= hs_n;
        vga_vs      <= vs_n;
        vga_blank_n <= active;
      end
    end
  end

endmodule
